// File: rtl/control_pkg.sv
// Shared encodings for the LEGv8-subset control unit: FSM states, PC-select and
// ALU function codes, opcode constants and the control-word layout.
package control_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;
  localparam logic [1:0] PS_JUMP   = 2'b11;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  // Bit positions of each field inside the 26-bit control word.
  localparam int CW_PS_LSB  = 24;
  localparam int CW_DA_LSB  = 19;
  localparam int CW_SA_LSB  = 14;
  localparam int CW_SB_LSB  = 9;
  localparam int CW_FS_LSB  = 4;
  localparam int CW_REGW    = 3;
  localparam int CW_RAMW    = 2;
  localparam int CW_SELALU  = 1;
  localparam int CW_SELK    = 0;

  typedef struct packed {
    logic [1:0] ps;
    logic [4:0] da;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] fs;
    logic       reg_w;
    logic       ram_w;
    logic       sel_alu;
    logic       sel_k;
  } ctrl_word_t;

  function automatic logic [4:0] rtype_fs(input logic [10:0] op);
    case (op)
      OP_SUB:  return FS_SUB;
      OP_AND:  return FS_AND;
      OP_ORR:  return FS_OR;
      default: return FS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_fsm_if.sv
// Bundle between instruction memory / datapath and the control unit.
interface control_unit_fsm_if #(parameter int RETIRE_W = 32);
  logic [31:0]         instruction;
  logic [3:0]          status;
  logic [25:0]         controlWord;
  logic [63:0]         K;
  logic [1:0]          state;
  logic                halted;
  logic [RETIRE_W-1:0] retired;

  modport master (input instruction, status,
                  output controlWord, K, state, halted, retired);
  modport slave  (output instruction, status,
                  input controlWord, K, state, halted, retired);
endinterface

// File: rtl/control_unit_fsm_decoder.sv
// Combinational decode of the latched instruction into control word and constant K.
// Only EXEC and MEM produce a non-idle word; status feeds nothing but PS.
module instr_decoder
  import control_pkg::*;
(
  input  logic [31:0] ir,
  input  logic [3:0]  status,
  input  state_t      state,
  output ctrl_word_t  cw,
  output logic [63:0] k,
  output logic        valid,
  output logic        is_load
);
  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rd, rn, rm;
  logic [63:0] k_imm12, k_d9, k_cb, k_b;

  assign op11 = ir[31:21];
  assign op10 = ir[31:22];
  assign op8  = ir[31:24];
  assign op6  = ir[31:26];
  assign rd   = ir[4:0];
  assign rn   = ir[9:5];
  assign rm   = ir[20:16];

  assign k_imm12 = {52'b0, ir[21:10]};
  assign k_d9    = {{55{ir[20]}}, ir[20:12]};
  assign k_cb    = {{43{ir[23]}}, ir[23:5], 2'b00};
  assign k_b     = {{36{ir[25]}}, ir[25:0], 2'b00};

  always_comb begin
    cw      = '0;
    k       = '0;
    valid   = 1'b0;
    is_load = 1'b0;
    if (state == S_EXEC || state == S_MEM) begin
      // Longest opcode wins: 11-bit, then 10, 8, 6.
      if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND || op11 == OP_ORR) begin
        valid      = 1'b1;
        cw.ps      = PS_INC;
        cw.da      = rd;
        cw.sa      = rn;
        cw.sb      = rm;
        cw.fs      = rtype_fs(op11);
        cw.reg_w   = 1'b1;
        cw.sel_alu = 1'b1;
      end else if (op11 == OP_LDUR) begin
        valid    = 1'b1;
        is_load  = 1'b1;
        cw.sa    = rn;
        cw.fs    = FS_ADD;
        cw.sel_k = 1'b1;
        k        = k_d9;
        if (state == S_MEM) begin
          cw.da    = rd;
          cw.reg_w = 1'b1;
          cw.ps    = PS_INC;
        end else begin
          cw.sel_alu = 1'b1;
        end
      end else if (op11 == OP_STUR) begin
        valid      = 1'b1;
        cw.ps      = PS_INC;
        cw.sa      = rn;
        cw.sb      = rd;
        cw.fs      = FS_ADD;
        cw.ram_w   = 1'b1;
        cw.sel_alu = 1'b1;
        cw.sel_k   = 1'b1;
        k          = k_d9;
      end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
        valid      = 1'b1;
        cw.ps      = PS_INC;
        cw.da      = rd;
        cw.sa      = rn;
        cw.fs      = (op10 == OP_SUBI) ? FS_SUB : FS_ADD;
        cw.reg_w   = 1'b1;
        cw.sel_alu = 1'b1;
        cw.sel_k   = 1'b1;
        k          = k_imm12;
      end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
        valid      = 1'b1;
        cw.sa      = rd;
        cw.sb      = 5'd31;
        cw.fs      = FS_OR;
        cw.sel_alu = 1'b1;
        k          = k_cb;
        cw.ps      = ((op8 == OP_CBZ) == status[0]) ? PS_BRANCH : PS_INC;
      end else if (op6 == OP_B) begin
        valid      = 1'b1;
        cw.ps      = PS_BRANCH;
        cw.sel_alu = 1'b1;
        k          = k_b;
      end
      if (!valid || (state == S_MEM && !is_load)) begin
        cw = '0;
        k  = '0;
      end
    end
  end
endmodule

// File: rtl/control_unit_fsm.sv
// Multi-cycle LEGv8-subset control unit: FETCH/EXEC/MEM/HALT sequencer holding
// the instruction register and a retired-instruction counter.
module control_unit_fsm
  import control_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input logic                 clock,
  input logic                 reset,
  control_unit_fsm_if.master  bus
);
  state_t              st, st_nxt;
  logic [31:0]         ir;
  logic [RETIRE_W-1:0] retired;
  logic                retire;
  logic                valid, is_load;
  ctrl_word_t          cw;
  logic [63:0]         k;

  instr_decoder u_dec (
    .ir      (ir),
    .status  (bus.status),
    .state   (st),
    .cw      (cw),
    .k       (k),
    .valid   (valid),
    .is_load (is_load)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= S_FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      st <= st_nxt;
      if (st == S_FETCH) ir <= bus.instruction;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    st_nxt = st;
    retire = 1'b0;
    case (st)
      S_FETCH: st_nxt = S_EXEC;
      S_EXEC: begin
        if (!valid) st_nxt = S_HALT;
        else if (is_load) st_nxt = S_MEM;
        else begin
          st_nxt = S_FETCH;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        st_nxt = S_FETCH;
        retire = 1'b1;
      end
      default: st_nxt = S_HALT;
    endcase
  end

  assign bus.controlWord = cw;
  assign bus.K           = k;
  assign bus.state       = st;
  assign bus.halted      = (st == S_HALT);
  assign bus.retired     = retired;
endmodule
